// File: rtl/debug_pkg.sv
// Shared constants for the serial debug daisy chain: frame layout, op codes,
// response status codes and the host frame engine state encoding.
package debug_pkg;

   localparam int          DBG_BITS       = 128;
   localparam int          FW             = DBG_BITS + 16;

   localparam logic [14:0] BROADCAST_ADDR = 15'h7FFF;
   localparam logic [7:0]  READ_CMD_IDENT = 8'h00;

   localparam logic [1:0]  OP_ENUM  = 2'd0;
   localparam logic [1:0]  OP_READ  = 2'd1;
   localparam logic [1:0]  OP_WRITE = 2'd2;
   localparam logic [1:0]  OP_RSVD  = 2'd3;

   localparam logic [1:0]  ST_OK           = 2'd0;
   localparam logic [1:0]  ST_TIMEOUT      = 2'd1;
   localparam logic [1:0]  ST_HDR_MISMATCH = 2'd2;
   localparam logic [1:0]  ST_BAD_OP       = 2'd3;

   localparam logic [1:0]  S_IDLE    = 2'd0;
   localparam logic [1:0]  S_XFER    = 2'd1;
   localparam logic [1:0]  S_WAIT_RX = 2'd2;
   localparam logic [1:0]  S_RESP    = 2'd3;

   // Header word: address above, direction (1 = write) in bit 0.
   function automatic logic [15:0] frame_hdr(input logic [14:0] addr, input logic dir);
      return {addr, dir};
   endfunction

endpackage

// File: rtl/debug_frame_rx.sv
// Chain-tail receiver: synchronises the asynchronous rx clock/data, detects
// edges and shifts in one FW-bit frame per arming, MSB first.
module debug_frame_rx #(
   parameter int FW = 144
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_clk,
   input  logic          rx_data,
   input  logic          arm,
   output logic          done,
   output logic [FW-1:0] frame,
   output logic          edge_pulse
);

   localparam int CW = $clog2(FW + 1);

   logic [2:0]    clk_sync_q, clk_sync_d;
   logic [2:0]    data_sync_q, data_sync_d;
   logic          capturing_q, capturing_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          rise, fall;

   assign rise = clk_sync_q[1] & ~clk_sync_q[2];
   assign fall = ~clk_sync_q[1] & clk_sync_q[2];

   // Capture control: a fall opens the frame, every rise takes one bit;
   // done stays set until the host drops arm.
   always_comb begin
      clk_sync_d  = {clk_sync_q[1:0], rx_clk};
      data_sync_d = {data_sync_q[1:0], rx_data};
      capturing_d = capturing_q;
      done_d      = done_q;
      cnt_d       = cnt_q;
      frame_d     = frame_q;
      if (!arm) begin
         capturing_d = 1'b0;
         done_d      = 1'b0;
         cnt_d       = CW'(FW);
      end else if (!done_q) begin
         if (!capturing_q) begin
            if (fall) begin
               capturing_d = 1'b1;
               cnt_d       = CW'(FW);
            end
         end else if (rise) begin
            frame_d = {frame_q[FW-2:0], data_sync_q[2]};
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               done_d      = 1'b1;
               capturing_d = 1'b0;
            end
         end
      end
   end

   // State and synchroniser registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         capturing_q <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= CW'(FW);
         frame_q     <= '0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         capturing_q <= capturing_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         frame_q     <= frame_d;
      end
   end

   assign done       = done_q;
   assign frame      = frame_q;
   assign edge_pulse = rise | fall;

endmodule

// File: rtl/debug_host_link.sv
// Host frame engine at the root of the debug daisy chain.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for a command; waits for the inter-frame guard to end
// S_XFER    | shifting the frame out on tx_data/tx_clk, receiver armed
// S_WAIT_RX | frame sent; waiting for capture or watchdog expiry
// S_RESP    | response presented until rsp_ready
module debug_host_link
   import debug_pkg::*;
#(
   parameter int          BITS    = 128,
   parameter logic [23:0] TIMEOUT = 24'h100000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      prescaler,
   output logic            tx_data,
   output logic            tx_clk,
   input  logic            rx_data,
   input  logic            rx_clk,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [14:0]     cmd_addr,
   input  logic [BITS-1:0] cmd_payload,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [BITS-1:0] rsp_payload,
   output logic [1:0]      rsp_status,
   output logic            busy
);

   localparam int FWL = BITS + 16;
   localparam int BW  = $clog2(FWL);

   logic [1:0]      state_q, state_d;
   logic [7:0]      p_q, p_d;
   logic [FWL-1:0]  frame_q, frame_d, frame_new;
   logic [BW-1:0]   bit_q, bit_d;
   logic            phase_q, phase_d;
   logic [7:0]      hcnt_q, hcnt_d;
   logic [23:0]     wd_q, wd_d;
   logic [7:0]      guard_q, guard_d;
   logic            tx_clk_q, tx_clk_d;
   logic            tx_data_q, tx_data_d;
   logic [BITS-1:0] rsp_payload_q, rsp_payload_d;
   logic [1:0]      rsp_status_q, rsp_status_d;

   logic            rx_arm, rx_done, rx_edge;
   logic [FWL-1:0]  rx_frame;

   assign rx_arm = (state_q == S_XFER) || (state_q == S_WAIT_RX);

   debug_frame_rx #(.FW(FWL)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_clk     (rx_clk),
      .rx_data    (rx_data),
      .arm        (rx_arm),
      .done       (rx_done),
      .frame      (rx_frame),
      .edge_pulse (rx_edge)
   );

   // Half-period floor of 2 keeps tx_clk slow enough for the 3-flop rx sync.
   always_comb begin
      p_d = (prescaler < 8'd2) ? 8'd2 : prescaler;
   end

   // Frame assembly for the command on the input port.
   always_comb begin
      frame_new = {cmd_payload, frame_hdr(cmd_addr, cmd_op == OP_WRITE)};
      if (cmd_op == OP_ENUM) begin
         frame_new = {{BITS{1'b0}}, frame_hdr(BROADCAST_ADDR, 1'b0)};
      end
   end

   // Sequencer: serialiser, watchdog (down-counter) and guard timer.
   always_comb begin
      state_d       = state_q;
      frame_d       = frame_q;
      bit_d         = bit_q;
      phase_d       = phase_q;
      hcnt_d        = hcnt_q;
      wd_d          = wd_q;
      guard_d       = (guard_q != 8'd0) ? guard_q - 8'd1 : guard_q;
      tx_clk_d      = tx_clk_q;
      tx_data_d     = tx_data_q;
      rsp_payload_d = rsp_payload_q;
      rsp_status_d  = rsp_status_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && guard_q == 8'd0) begin
               if (cmd_op == OP_RSVD) begin
                  state_d       = S_RESP;
                  rsp_status_d  = ST_BAD_OP;
                  rsp_payload_d = '0;
               end else begin
                  state_d   = S_XFER;
                  frame_d   = frame_new;
                  bit_d     = BW'(FWL - 1);
                  phase_d   = 1'b0;
                  hcnt_d    = p_q - 8'd1;
                  wd_d      = TIMEOUT - 24'd1;
                  tx_clk_d  = 1'b0;
                  tx_data_d = frame_new[FWL-1];
               end
            end
         end
         S_XFER: begin
            if (hcnt_q != 8'd0) begin
               hcnt_d = hcnt_q - 8'd1;
            end else if (!phase_q) begin
               tx_clk_d = 1'b1;
               phase_d  = 1'b1;
               hcnt_d   = p_q - 8'd1;
            end else if (bit_q == '0) begin
               tx_data_d = 1'b0;
               guard_d   = p_q;
               state_d   = S_WAIT_RX;
            end else begin
               bit_d     = bit_q - 1'b1;
               tx_data_d = frame_q[bit_q - 1'b1];
               tx_clk_d  = 1'b0;
               phase_d   = 1'b0;
               hcnt_d    = p_q - 8'd1;
            end
         end
         S_WAIT_RX: begin
            if (rx_done) begin
               state_d       = S_RESP;
               rsp_payload_d = rx_frame[FWL-1:16];
               rsp_status_d  = (rx_frame[15:0] != frame_q[15:0]) ? ST_HDR_MISMATCH : ST_OK;
            end else if (wd_q == 24'd0) begin
               state_d       = S_RESP;
               rsp_payload_d = '0;
               rsp_status_d  = ST_TIMEOUT;
            end else if (rx_edge) begin
               wd_d = TIMEOUT - 24'd1;
            end else begin
               wd_d = wd_q - 24'd1;
            end
         end
         default: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // Registers; prescaler is captured only while reset is held.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         p_q           <= p_d;
         frame_q       <= '0;
         bit_q         <= '0;
         phase_q       <= 1'b0;
         hcnt_q        <= '0;
         wd_q          <= TIMEOUT - 24'd1;
         guard_q       <= '0;
         tx_clk_q      <= 1'b1;
         tx_data_q     <= 1'b0;
         rsp_payload_q <= '0;
         rsp_status_q  <= ST_OK;
      end else begin
         state_q       <= state_d;
         p_q           <= p_q;
         frame_q       <= frame_d;
         bit_q         <= bit_d;
         phase_q       <= phase_d;
         hcnt_q        <= hcnt_d;
         wd_q          <= wd_d;
         guard_q       <= guard_d;
         tx_clk_q      <= tx_clk_d;
         tx_data_q     <= tx_data_d;
         rsp_payload_q <= rsp_payload_d;
         rsp_status_q  <= rsp_status_d;
      end
   end

   assign tx_clk      = tx_clk_q;
   assign tx_data     = tx_data_q;
   assign cmd_ready   = rst_n && (state_q == S_IDLE) && (guard_q == 8'd0);
   assign busy        = (state_q != S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_payload = rsp_payload_q;
   assign rsp_status  = rsp_status_q;

endmodule

// File: tb/tb_debug_host_link.sv
// Directed bench for debug_host_link: loopback, a behavioural 3-node chain,
// a tied-off chain for the watchdog, header corruption and mid-frame reset.
module tb_debug_host_link;

   localparam int FW   = 144;
   localparam int M_HP = 3;

   localparam logic [1:0] M_LOOP    = 2'd0;
   localparam logic [1:0] M_CHAIN   = 2'd1;
   localparam logic [1:0] M_TIE     = 2'd2;
   localparam logic [1:0] M_CORRUPT = 2'd3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   prescaler;
   logic         tx_data, tx_clk, rx_data, rx_clk;
   logic         cmd_valid, cmd_ready;
   logic [1:0]   cmd_op;
   logic [14:0]  cmd_addr;
   logic [127:0] cmd_payload;
   logic         rsp_valid, rsp_ready, busy;
   logic [127:0] rsp_payload;
   logic [1:0]   rsp_status;
   logic [1:0]   mode;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   debug_host_link #(.BITS(128), .TIMEOUT(24'd1000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .prescaler   (prescaler),
      .tx_data     (tx_data),
      .tx_clk      (tx_clk),
      .rx_data     (rx_data),
      .rx_clk      (rx_clk),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_payload (cmd_payload),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_payload (rsp_payload),
      .rsp_status  (rsp_status),
      .busy        (busy)
   );

   // ---------------- behavioural chain of three nodes ----------------
   logic         m_clk = 1'b1, m_data = 1'b0, m_txc_s = 1'b1;
   logic [FW-1:0] m_frame, m_reply;
   int           m_phase = 0, m_bits = 0, m_gap = 0, m_idx = 0, m_hcnt = 0;
   logic [127:0] node2_data = '0;
   logic         node2_tgl = 1'b0;

   assign rx_clk  = (mode == M_LOOP) ? tx_clk  : (mode == M_TIE) ? 1'b1 : m_clk;
   assign rx_data = (mode == M_LOOP) ? tx_data : (mode == M_TIE) ? 1'b0 : m_data;

   function automatic logic [127:0] node_ident(input logic [14:0] a);
      return {48'hC0DE_0000_0000, 1'b0, a, 64'h0123_4567_89AB_CDEF};
   endfunction

   function automatic logic [FW-1:0] chain_reply(input logic [FW-1:0] f);
      logic [127:0] pl;
      pl = f[FW-1:16];
      if (!f[0] && f[15:1] == 15'h7FFF) pl[14:0] = pl[14:0] + 15'd3;
      else if (!f[0] && f[15:1] >= 15'd1 && f[15:1] <= 15'd3)
         pl = (pl[7:0] == 8'h00) ? node_ident(f[15:1]) : 128'd0;
      return {pl, f[15:0]};
   endfunction

   always @(negedge clk) begin
      if (!busy) begin
         m_phase = 0; m_bits = 0; m_clk = 1'b1; m_data = 1'b0;
      end else begin
         case (m_phase)
            0: if (tx_clk && !m_txc_s) begin
                  m_frame = {m_frame[FW-2:0], tx_data};
                  m_bits++;
                  if (m_bits == FW) begin
                     m_reply = chain_reply(m_frame);
                     if (m_frame[0] && m_frame[15:1] == 15'd2) begin
                        node2_data = m_frame[FW-1:16];
                        node2_tgl  = ~node2_tgl;
                     end
                     if (mode == M_CORRUPT) m_reply[2] = ~m_reply[2];
                     m_gap = 20; m_phase = 1;
                  end
               end
            1: if (m_gap == 0) begin
                  m_phase = 2; m_idx = FW - 1; m_hcnt = M_HP;
                  m_clk = 1'b0; m_data = m_reply[FW-1];
               end else m_gap--;
            2: begin
                  m_hcnt--;
                  if (m_hcnt == 0) begin
                     if (!m_clk) begin m_clk = 1'b1; m_hcnt = M_HP; end
                     else if (m_idx == 0) begin m_data = 1'b0; m_phase = 3; end
                     else begin m_idx--; m_clk = 1'b0; m_data = m_reply[m_idx]; m_hcnt = M_HP; end
                  end
               end
            default: ;
         endcase
      end
      m_txc_s = tx_clk;
   end

   // ---------------- tx_clk monitor ----------------
   int   cyc = 0, falls = 0, run_len = 0, last_rise_cyc = 0, rsp_rise_cyc = 0;
   int   min_low = 0, max_low = 0, min_high = 0, max_high = 0;
   logic mon_busy_s = 1'b0, mon_txc_s = 1'b1, mon_rv_s = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (busy && !mon_busy_s) begin
         falls = 0; min_low = 1000; max_low = 0; min_high = 1000; max_high = 0;
      end
      if (tx_clk !== mon_txc_s) begin
         if (!tx_clk) begin
            if (falls > 0) begin
               if (run_len < min_high) min_high = run_len;
               if (run_len > max_high) max_high = run_len;
            end
            falls++;
         end else begin
            if (run_len < min_low) min_low = run_len;
            if (run_len > max_low) max_low = run_len;
            last_rise_cyc = cyc;
         end
         run_len = 1;
      end else run_len++;
      if (rsp_valid && !mon_rv_s) rsp_rise_cyc = cyc;
      mon_busy_s = busy; mon_txc_s = tx_clk; mon_rv_s = rsp_valid;
   end

   // ---------------- helpers ----------------
   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input logic [7:0] pre);
      @(negedge clk);
      rst_n = 1'b0; prescaler = pre;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [14:0] addr, input logic [127:0] pl);
      int n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_payload = pl;
      while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
      if (n == 1000) check_val("cmd_ready_wait", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int max, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < max);
      #1;
      if (!rsp_valid) check_val("rsp_wait", rsp_valid, 1);
   endtask

   task automatic ack_rsp();
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1; rsp_ready = 1'b0;
      @(negedge clk);
      check_val("idle_after_ack", busy, 0);
   endtask

   // ---------------- directed sequence ----------------
   int n;

   initial begin
      rst_n = 1'b0; prescaler = 8'd4; mode = M_LOOP;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_payload = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_tx_clk", tx_clk, 1);
      check_val("rst_tx_data", tx_data, 0);
      check_val("rst_cmd_ready", cmd_ready, 0);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_rsp_payload", rsp_payload, 0);
      check_val("rst_rsp_status", rsp_status, 0);
      check_val("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("first_idle_ready", cmd_ready, 1);

      // loopback ENUM, P = 4; the payload on the port must be ignored
      send_cmd(2'd0, 15'h0012, 128'hFFFF_0000_1234);
      wait_rsp(5000, n);
      check_val("loop_status", rsp_status, 0);
      check_val("loop_payload", rsp_payload, 0);
      check_val("loop_falls", falls, 144);
      check_val("loop_min_low", min_low, 4);
      check_val("loop_max_low", max_low, 4);
      check_val("loop_min_high", min_high, 4);
      check_val("loop_max_high", max_high, 4);
      ack_rsp();

      // three-node chain
      mode = M_CHAIN;
      send_cmd(2'd0, 15'h0000, 128'd0);
      wait_rsp(5000, n);
      check_val("chain_enum_status", rsp_status, 0);
      check_val("chain_enum_count", rsp_payload, 128'd3);
      ack_rsp();

      send_cmd(2'd1, 15'd1, 128'd0);
      wait_rsp(5000, n);
      check_val("read_ident_status", rsp_status, 0);
      check_val("read_ident_payload", rsp_payload, 128'hC0DE_0000_0000_0001_0123_4567_89AB_CDEF);
      ack_rsp();

      send_cmd(2'd2, 15'd2, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE);
      wait_rsp(5000, n);
      check_val("write_status", rsp_status, 0);
      check_val("write_echo", rsp_payload, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE);
      check_val("node2_data", node2_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_FACE);
      check_val("node2_tgl", node2_tgl, 1);
      ack_rsp();

      // reserved op: immediate response, no frame
      send_cmd(2'd3, 15'd1, 128'h55);
      wait_rsp(5, n);
      check_val("badop_latency", n, 1);
      check_val("badop_status", rsp_status, 3);
      check_val("badop_payload", rsp_payload, 0);
      check_val("badop_no_tx", falls, 0);
      ack_rsp();

      // header corrupted on the way back
      mode = M_CORRUPT;
      send_cmd(2'd1, 15'd3, 128'd0);
      wait_rsp(5000, n);
      check_val("hdr_status", rsp_status, 2);
      check_val("hdr_payload", rsp_payload, 128'hC0DE_0000_0000_0003_0123_4567_89AB_CDEF);
      ack_rsp();

      // rx_clk stuck high: watchdog of 1000 after the final high half (P = 4)
      mode = M_TIE;
      send_cmd(2'd0, 15'd0, 128'd0);
      wait_rsp(5000, n);
      check_val("timeout_status", rsp_status, 1);
      check_val("timeout_payload", rsp_payload, 0);
      check_val("timeout_latency", rsp_rise_cyc - last_rise_cyc, 1004);
      repeat (20) @(negedge clk);
      check_val("timeout_held", rsp_valid, 1);
      check_val("timeout_held_status", rsp_status, 1);
      ack_rsp();

      // reset while bit 70 is on the wire
      mode = M_LOOP;
      send_cmd(2'd0, 15'd0, 128'd0);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (falls < 71 && n < 3000);
      check_val("reached_bit70", falls, 71);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("midrst_tx_clk", tx_clk, 1);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_rsp_valid", rsp_valid, 0);
      rst_n = 1'b1;
      send_cmd(2'd0, 15'd0, 128'd0);
      wait_rsp(5000, n);
      check_val("post_rst_status", rsp_status, 0);
      check_val("post_rst_falls", falls, 144);
      ack_rsp();

      // prescaler 0 clamps to a half-period of 2
      do_reset(8'd0);
      send_cmd(2'd0, 15'd0, 128'd0);
      wait_rsp(5000, n);
      check_val("p0_status", rsp_status, 0);
      check_val("p0_min_low", min_low, 2);
      check_val("p0_max_low", max_low, 2);
      check_val("p0_min_high", min_high, 2);
      check_val("p0_max_high", max_high, 2);
      ack_rsp();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
